// File: rtl/mem_read_arbiter_if.sv
// Read-burst bus shared by the requester ports and the memory read channels.
// slave is the arbiter's view, master is the requester/memory environment.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface mem_read_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
);
  logic [N_REQ-1:0]             req_arvalid;
  logic [N_REQ-1:0][ADDR_W-1:0] req_araddr;
  logic [N_REQ-1:0][4:0]        req_arlen;
  logic [N_REQ-1:0]             req_arready;
  logic [N_REQ-1:0]             req_rvalid;
  logic [DATA_W-1:0]            req_rdata;

  logic [ADDR_W-1:0]            mem_araddr;
  logic [4:0]                   mem_arlen;
  logic [3:0]                   mem_arid;
  logic                         mem_arvalid;
  logic                         mem_arready;
  logic                         mem_rvalid;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         mem_rready;

  modport slave (
    input  req_arvalid, req_araddr, req_arlen, mem_arready, mem_rvalid, mem_rdata,
    output req_arready, req_rvalid, req_rdata,
           mem_araddr, mem_arlen, mem_arid, mem_arvalid, mem_rready
  );

  modport master (
    output req_arvalid, req_araddr, req_arlen, mem_arready, mem_rvalid, mem_rdata,
    input  req_arready, req_rvalid, req_rdata,
           mem_araddr, mem_arlen, mem_arid, mem_arvalid, mem_rready
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Three-way read-burst arbiter: round-robin between d-cache and i-cache,
// prefetch only when both are idle; one burst outstanding at a time.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_read_arbiter #(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH,
  parameter int N_REQ  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_read_arbiter_if.slave bus,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic              last_grant;   // 1: requester 1 won last, so 0 wins a tie
  logic [1:0]        grant_idx;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        len_q;
  logic [4:0]        cnt;
  logic              mem_arvalid_q;
  logic              mem_rready_q;

  logic              arb_vld;
  logic [1:0]        arb_idx;
  logic [N_REQ-1:0]  arready_d;
  logic [N_REQ-1:0]  rvalid_d;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    arb_vld = 1'b0;
    arb_idx = 2'd0;
    if (bus.req_arvalid[0] && bus.req_arvalid[1]) begin
      arb_vld = 1'b1;
      arb_idx = last_grant ? 2'd0 : 2'd1;
    end else if (bus.req_arvalid[0]) begin
      arb_vld = 1'b1;
      arb_idx = 2'd0;
    end else if (bus.req_arvalid[1]) begin
      arb_vld = 1'b1;
      arb_idx = 2'd1;
    end else if (bus.req_arvalid[2]) begin
      arb_vld = 1'b1;
      arb_idx = 2'd2;
    end
  end

  // Accept and beat strobes are combinational so they line up with the
  // cycle the request or memory beat is presented; rst_n masks the accept.
  always_comb begin
    arready_d = '0;
    rvalid_d  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      arready_d[i] = rst_n && (state == IDLE) && arb_vld && (arb_idx == i[1:0]);
      rvalid_d[i]  = (state == DATA) && bus.mem_rvalid && (grant_idx == i[1:0]);
    end
  end

  assign rdata           = bus.mem_rdata;
  assign bus.req_rdata   = rdata;
  assign bus.req_arready = arready_d;
  assign bus.req_rvalid  = rvalid_d;
  assign bus.mem_araddr  = addr_q;
  assign bus.mem_arlen   = len_q;
  assign bus.mem_arid    = {2'b00, grant_idx};
  assign bus.mem_arvalid = mem_arvalid_q;
  assign bus.mem_rready  = mem_rready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant_idx     <= 2'd0;
      addr_q        <= '0;
      len_q         <= '0;
      cnt           <= '0;
      mem_arvalid_q <= 1'b0;
      mem_rready_q  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            grant_idx     <= arb_idx;
            addr_q        <= bus.req_araddr[arb_idx];
            len_q         <= bus.req_arlen[arb_idx];
            if (arb_idx != 2'd2) last_grant <= arb_idx[0];
            mem_arvalid_q <= 1'b1;
            busy          <= 1'b1;
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (bus.mem_arready) begin
            mem_arvalid_q <= 1'b0;
            mem_rready_q  <= 1'b1;
            cnt           <= (len_q == 5'd0) ? 5'd1 : len_q;
            state         <= DATA;
          end
        end
        DATA: begin
          if (bus.mem_rvalid) begin
            cnt <= cnt - 5'd1;
            if (cnt <= 5'd1) begin
              mem_rready_q <= 1'b0;
              busy         <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: a memory model pushes each beat it
// drives, a negedge monitor pops and matches it against req_rvalid/req_rdata.
module tb_mem_read_arbiter;

  logic clk;
  logic rst_n;
  logic busy;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t      sb[$];
  logic [1:0] gnt_q[$];
  int         n_tests;
  int         n_fail;

  mem_read_arbiter_if #(.N_REQ(3), .ADDR_W(32), .DATA_W(32)) bus ();

  mem_read_arbiter #(.ADDR_W(32), .DATA_W(32), .N_REQ(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // Grant log and beat scoreboard
  always @(negedge clk) begin
    beat_t exp;
    if (rst_n === 1'b1) begin
      if (|bus.req_arready) begin
        n_tests++;
        if ($countones(bus.req_arready) != 1) begin
          n_fail++;
          $display("FAIL arready_onehot: got %b, required one-hot", bus.req_arready);
        end
        gnt_q.push_back(bus.req_arready[2] ? 2'd2 : (bus.req_arready[1] ? 2'd1 : 2'd0));
      end
      if (|bus.req_rvalid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: req_rvalid=%b, required 000 (no beat outstanding)",
                   bus.req_rvalid);
        end else begin
          exp = sb.pop_front();
          if (bus.req_rvalid !== (3'b001 << exp.idx) || bus.req_rdata !== exp.data) begin
            n_fail++;
            $display("FAIL beat_match: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                     bus.req_rvalid, bus.req_rdata, 3'b001 << exp.idx, exp.data);
          end
        end
      end
    end
  end

  // Memory-side model for one burst: waits for the address, holds mem_arready
  // low for `stall` cycles of mem_arvalid, then returns `nbeats` beats.
  task automatic serve(input int stall, input int nbeats, input logic [2:0] drop_mask,
                       input logic [1:0] idx, output logic [31:0] a, output logic [4:0] l,
                       output logic [3:0] id, output int bad);
    bit seen;
    logic [31:0] d;
    seen = 1'b0;
    bad  = 0;
    a    = '0;
    l    = '0;
    id   = '0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_arvalid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      bad = 1000;
      return;
    end
    a  = bus.mem_araddr;
    l  = bus.mem_arlen;
    id = bus.mem_arid;
    for (int s = 1; s < stall; s++) begin
      @(posedge clk); #1;
      if (s == 1) bus.req_arvalid = bus.req_arvalid & ~drop_mask;
      @(negedge clk);
      if (bus.mem_arvalid !== 1'b1 || bus.mem_araddr !== a || bus.mem_arlen !== l ||
          bus.mem_arid !== id || bus.req_arready !== 3'b000)
        bad++;
    end
    @(posedge clk); #1;
    if (stall <= 1) bus.req_arvalid = bus.req_arvalid & ~drop_mask;
    bus.mem_arready = 1'b1;
    @(posedge clk); #1;
    bus.mem_arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d = $urandom;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = d;
      sb.push_back('{idx: idx, data: d});
      @(posedge clk); #1;
    end
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_arvalid = 3'b111;
    bus.mem_rvalid  = 1'b1;
    bus.mem_arready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.req_arready, bus.req_rvalid, bus.mem_arvalid, bus.mem_rready, busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: arready=%b rvalid=%b arvalid=%b rready=%b busy=%b, required all 0",
               bus.req_arready, bus.req_rvalid, bus.mem_arvalid, bus.mem_rready, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.req_arready, bus.req_rvalid, bus.mem_arvalid, bus.mem_rready, busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_held: arready=%b rvalid=%b arvalid=%b rready=%b busy=%b, required all 0",
               bus.req_arready, bus.req_rvalid, bus.mem_arvalid, bus.mem_rready, busy);
    end
    bus.req_arvalid = 3'b000;
    bus.mem_rvalid  = 1'b0;
    bus.mem_arready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || bus.mem_arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b arvalid=%b, required 0 0", busy, bus.mem_arvalid);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] a;
    logic [4:0]  l;
    logic [3:0]  id;
    logic [1:0]  e;
    int          bad;
    bit          ok;
    gnt_q.delete();
    @(posedge clk); #1;
    bus.req_araddr[0] = 32'h40;
    bus.req_araddr[1] = 32'h80;
    bus.req_arlen[0]  = 5'd1;
    bus.req_arlen[1]  = 5'd1;
    bus.req_arvalid   = 3'b011;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 2'd0 : 2'd1;
      serve(1, 1, 3'b000, e, a, l, id, bad);
      n_tests++;
      if (bad != 0 || id !== {2'b00, e} || a !== ((e == 2'd0) ? 32'h40 : 32'h80)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: id=%0d addr=%h bad=%0d, required id=%0d addr=%h bad=0",
                 k, id, a, bad, e, (e == 2'd0) ? 32'h40 : 32'h80);
      end
    end
    bus.req_arvalid = 3'b000;
    @(negedge clk);
    ok = (gnt_q.size() == 4);
    for (int i = 0; i < 4 && ok; i++) if (gnt_q[i] !== i[1:0] % 2'd2) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_sequence: %0d grants logged %p, required 0,1,0,1", gnt_q.size(), gnt_q);
    end
  endtask

  task automatic test_single_icache();
    logic [31:0] a;
    logic [4:0]  l;
    logic [3:0]  id;
    int          bad;
    gnt_q.delete();
    @(posedge clk); #1;
    bus.req_araddr[1] = 32'h100;
    bus.req_arlen[1]  = 5'd4;
    bus.req_arvalid   = 3'b010;
    serve(1, 4, 3'b010, 2'd1, a, l, id, bad);
    n_tests++;
    if (bad != 0 || a !== 32'h100 || l !== 5'd4 || id !== 4'd1) begin
      n_fail++;
      $display("FAIL single_addr: addr=%h len=%0d id=%0d bad=%0d, required 100 4 1 0", a, l, id, bad);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || bus.mem_rready !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL single_done: busy=%b rready=%b pending=%0d, required 0 0 0",
               busy, bus.mem_rready, sb.size());
    end
    n_tests++;
    if (gnt_q.size() != 1 || gnt_q[0] !== 2'd1) begin
      n_fail++;
      $display("FAIL single_grants: %p, required exactly one grant to 1", gnt_q);
    end
  endtask

  task automatic test_prefetch_priority();
    logic [31:0] a;
    logic [4:0]  l;
    logic [3:0]  id;
    int          bad;
    gnt_q.delete();
    @(posedge clk); #1;
    bus.req_araddr[1] = 32'h140;
    bus.req_arlen[1]  = 5'd2;
    bus.req_araddr[2] = 32'h1c0;
    bus.req_arlen[2]  = 5'd3;
    bus.req_arvalid   = 3'b110;
    serve(2, 2, 3'b010, 2'd1, a, l, id, bad);
    n_tests++;
    if (bad != 0 || id !== 4'd1 || a !== 32'h140) begin
      n_fail++;
      $display("FAIL prio_first: id=%0d addr=%h bad=%0d, required 1 140 0", id, a, bad);
    end
    serve(1, 3, 3'b100, 2'd2, a, l, id, bad);
    n_tests++;
    if (bad != 0 || id !== 4'd2 || a !== 32'h1c0 || l !== 5'd3) begin
      n_fail++;
      $display("FAIL prio_second: id=%0d addr=%h len=%0d bad=%0d, required 2 1c0 3 0", id, a, l, bad);
    end
    // requester 1 won last; the prefetch grant must not disturb that
    bus.req_araddr[0] = 32'h20;
    bus.req_arlen[0]  = 5'd1;
    bus.req_arvalid   = 3'b011;
    serve(1, 1, 3'b001, 2'd0, a, l, id, bad);
    bus.req_arvalid = 3'b000;
    n_tests++;
    if (bad != 0 || id !== 4'd0) begin
      n_fail++;
      $display("FAIL prio_tie_after_pf: id=%0d bad=%0d, required 0 0", id, bad);
    end
    @(negedge clk);
    n_tests++;
    if (gnt_q.size() != 3 || gnt_q[0] !== 2'd1 || gnt_q[1] !== 2'd2 || gnt_q[2] !== 2'd0) begin
      n_fail++;
      $display("FAIL prio_grants: %p, required 1,2,0", gnt_q);
    end
  endtask

  task automatic test_addr_stall();
    logic [31:0] a;
    logic [4:0]  l;
    logic [3:0]  id;
    int          bad;
    gnt_q.delete();
    @(posedge clk); #1;
    bus.req_araddr[0] = 32'h200;
    bus.req_arlen[0]  = 5'd3;
    bus.req_arvalid   = 3'b001;
    serve(5, 3, 3'b001, 2'd0, a, l, id, bad);
    n_tests++;
    if (bad != 0 || a !== 32'h200 || l !== 5'd3 || id !== 4'd0) begin
      n_fail++;
      $display("FAIL stall_stable: addr=%h len=%0d id=%0d unstable_cycles=%0d, required 200 3 0 0",
               a, l, id, bad);
    end
    @(negedge clk);
    n_tests++;
    if (gnt_q.size() != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_grants: grants=%0d busy=%b, required 1 0", gnt_q.size(), busy);
    end
  endtask

  task automatic test_len_edges();
    logic [31:0] a;
    logic [4:0]  l;
    logic [3:0]  id;
    int          bad;
    @(posedge clk); #1;
    bus.req_araddr[0] = 32'h300;
    bus.req_arlen[0]  = 5'd0;
    bus.req_arvalid   = 3'b001;
    serve(1, 1, 3'b001, 2'd0, a, l, id, bad);
    @(negedge clk);
    n_tests++;
    if (bad != 0 || l !== 5'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_one_beat: arlen=%0d busy=%b bad=%0d, required 0 0 0", l, busy, bad);
    end
    @(posedge clk); #1;
    bus.req_araddr[1] = 32'h380;
    bus.req_arlen[1]  = 5'd16;
    bus.req_arvalid   = 3'b010;
    serve(1, 16, 3'b010, 2'd1, a, l, id, bad);
    @(negedge clk);
    n_tests++;
    if (bad != 0 || l !== 5'd16 || busy !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL len16_done: arlen=%0d busy=%b pending=%0d bad=%0d, required 16 0 0 0",
               l, busy, sb.size(), bad);
    end
  endtask

  task automatic test_stray_and_reset();
    logic [31:0] a;
    logic [4:0]  l;
    logic [3:0]  id;
    int          bad;
    gnt_q.delete();
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hdead_beef;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.req_rvalid !== 3'b000 || bus.mem_rready !== 1'b0) begin
        n_fail++;
        $display("FAIL stray_beat%0d: rvalid=%b rready=%b, required 000 0", c, bus.req_rvalid, bus.mem_rready);
      end
    end
    @(posedge clk); #1;
    bus.mem_rvalid    = 1'b0;
    bus.req_araddr[1] = 32'h500;
    bus.req_arlen[1]  = 5'd8;
    bus.req_arvalid   = 3'b010;
    serve(1, 2, 3'b010, 2'd1, a, l, id, bad);
    bus.mem_rvalid    = 1'b1;
    bus.mem_rdata     = 32'h1234_5678;
    bus.req_araddr[0] = 32'h400;
    bus.req_arlen[0]  = 5'd2;
    bus.req_arvalid   = 3'b001;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.req_arready, bus.req_rvalid, bus.mem_arvalid, bus.mem_rready, busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL midburst_reset: arready=%b rvalid=%b arvalid=%b rready=%b busy=%b, required all 0",
               bus.req_arready, bus.req_rvalid, bus.mem_arvalid, bus.mem_rready, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b0;
    rst_n = 1'b1;
    serve(1, 2, 3'b001, 2'd0, a, l, id, bad);
    @(negedge clk);
    n_tests++;
    if (bad != 0 || a !== 32'h400 || id !== 4'd0 || busy !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_grant: addr=%h id=%0d busy=%b pending=%0d bad=%0d, required 400 0 0 0 0",
               a, id, busy, sb.size(), bad);
    end
    n_tests++;
    if (gnt_q.size() != 2 || gnt_q[0] !== 2'd1 || gnt_q[1] !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_grants: %p, required 1,0", gnt_q);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req_arvalid = '0;
    bus.req_araddr  = '0;
    bus.req_arlen   = '0;
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    test_reset();
    test_round_robin();
    test_single_icache();
    test_prefetch_priority();
    test_addr_stall();
    test_len_edges();
    test_stray_and_reset();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default `ADDR_WIDTH, meaning the byte address width.
REQ-002 The block SHALL have parameter DATA_W, default `DATA_WIDTH, meaning the read data width.
REQ-003 The block SHALL have parameter N_REQ, fixed at 3, with index 0 = d-cache, 1 = i-cache, 2 = stream-buffer prefetch.
REQ-004 clk  input  1  is the single clock; all state SHALL be updated on the rising edge.
REQ-005 rst_n  input  1  is the reset, asynchronous and active-low.
REQ-006 req_arvalid  input  N_REQ  carries the per-requester burst request.
REQ-007 req_araddr  input  N_REQ x ADDR_W  carries the per-requester line-aligned start address.
REQ-008 req_arlen  input  N_REQ x 5  carries the per-requester beat count; valid values are 1..16.
REQ-009 req_arready  output  N_REQ  is the per-requester grant/accept strobe.
REQ-010 req_rvalid  output  N_REQ  is the per-requester data beat strobe.
REQ-011 req_rdata  output  DATA_W  is the shared return data bus.
REQ-012 mem_araddr, mem_arlen(5), mem_arid(4), mem_arvalid  output  form the memory read address channel.
REQ-013 mem_arready  input  1  is the memory address accept.
REQ-014 mem_rvalid  input  1  and mem_rdata  input  DATA_W  form the memory read data channel; mem_rready  output  1  is its ready.
REQ-015 busy  output  1  SHALL be high whenever state != IDLE.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, ADDR and DATA.
REQ-017 In IDLE with any req_arvalid high, the block SHALL grant exactly one requester, pulse its req_arready for that cycle, latch address, length and grant index, and go to ADDR.
REQ-018 Arbitration SHALL be round-robin between requesters 0 and 1 using a last-grant bit; on a tie, the requester not granted most recently wins.
REQ-019 Requester 2 SHALL be granted only when req_arvalid[0] and req_arvalid[1] are both low in that IDLE cycle; a requester 2 grant SHALL NOT update the last-grant bit.
REQ-020 In ADDR, mem_arvalid SHALL be 1 with the latched address, mem_arlen equal to the latched length, and mem_arid equal to the zero-extended grant index; all SHALL be held stable until mem_arready, then the FSM goes to DATA.
REQ-021 On entry to DATA, the beat counter SHALL load the latched length; a length of 0 SHALL be treated as 1.
REQ-022 In DATA, mem_rready SHALL be 1; each mem_rvalid beat SHALL drive req_rvalid[grant] = 1 combinationally, drive req_rdata = mem_rdata in the same cycle, and decrement the counter.
REQ-023 A beat arriving with counter == 1 SHALL return the FSM to IDLE; a new grant is possible in the following cycle.
REQ-024 Address-to-memory latency SHALL be 1 cycle: a grant in cycle N gives mem_arvalid in cycle N+1.
REQ-025 Outside DATA, mem_rready SHALL be 0, all req_rvalid SHALL be 0, and any mem_rvalid SHALL be ignored.
REQ-026 req_arready SHALL be 0 in ADDR and DATA; requests raised then SHALL wait, not be dropped by the arbiter.
REQ-027 A granted transaction SHALL complete fully even if the requester deasserts req_arvalid afterwards; withdrawal before grant SHALL have no effect.
REQ-028 At most one transaction SHALL be outstanding; req_rvalid SHALL be one-hot or zero at all times.
REQ-029 req_rdata SHALL equal mem_rdata whenever a req_rvalid bit is high; its value is don't-care otherwise.

Reset
REQ-030 When rst_n is low, the block SHALL immediately set state = IDLE, last-grant = 1 (so requester 0 wins the first tie), beat counter = 0, and mem_arvalid, mem_rready, req_arready, req_rvalid and busy all = 0.
REQ-031 Reset mid-burst SHALL abandon the transaction without draining it; the memory model shares rst_n.

Verification
REQ-032 Single i-cache request (addr 0x100, len 4), mem_arready 1 cycle later, 4 beats -> req_arready[1] pulses once, mem_arid = 1, req_rvalid[1] pulses 4 times, FSM back in IDLE after the 4th beat.
REQ-033 Requesters 0 and 1 held continuously high -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-034 Requesters 2 and 1 high together -> requester 1 is granted; requester 2 is granted only after requester 1 drops and the FSM is in IDLE.
REQ-035 mem_arready withheld for 5 cycles -> mem_arvalid, mem_araddr and mem_arlen are stable for all 5 cycles; no req_arready pulses during them.
REQ-036 Stray mem_rvalid in IDLE, and rst_n low after 2 of 8 beats -> no req_rvalid for the stray beat; all outputs drop to 0 immediately on reset and a new request is granted normally after rst_n rises.
